// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register and its skid stages.
// Holds the depth limit, the NOP control template and the occupancy width helper.
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 4;
    localparam int PIPE_CTRL_W    = 16;

    // Control bundle as seen by instantiating stages; all zeros is a NOP.
    typedef logic [PIPE_CTRL_W-1:0] ctrl_nop_t;
    localparam ctrl_nop_t CTRL_NOP = '0;

    // Counter must represent 0..2*depth inclusive.
    function automatic int occ_width(input int depth);
        int n;
        n = 2 * depth + 1;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One elastic stage: a main entry driving the output plus a skid entry that
// absorbs the beat accepted while main is stalled, so in_ready is registered.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              out_ready
);

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_fire;
    logic   out_fire;

    assign in_ready  = ~skid_q.v;
    assign in_fire   = in_valid & ~skid_q.v;
    assign out_fire  = main_q.v & out_ready;
    assign out_valid = main_q.v;
    assign out_data  = main_q.data;
    assign out_ctrl  = main_q.ctrl;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!main_q.v || out_fire) begin
            // A valid skid implies in_ready was low, so no new beat competes here.
            if (skid_q.v) begin
                main_d   = skid_q;
                skid_d.v = 1'b0;
            end else if (in_fire) begin
                main_d = '{v: 1'b1, data: in_data, ctrl: in_ctrl};
            end else begin
                main_d.v = 1'b0;
            end
        end else if (in_fire) begin
            skid_d = '{v: 1'b1, data: in_data, ctrl: in_ctrl};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH chained skid stages carrying payload + control, with synchronous flush
// and a count of beats currently held anywhere in the chain.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1,
    parameter int OCC_W  = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              out_ready,
    output logic [OCC_W-1:0]  occupancy
);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("elastic_pipe_reg: DEPTH must be within 1..PIPE_MAX_DEPTH");
    end

    // Link k sits between stage k-1 and stage k; link 0 is the block input.
    logic [DEPTH:0]             vld;
    logic [DEPTH:0]             rdy;
    logic [DEPTH:0][DATA_W-1:0] dat;
    logic [DEPTH:0][CTRL_W-1:0] ctl;

    assign vld[0]     = in_valid;
    assign dat[0]     = in_data;
    assign ctl[0]     = in_ctrl;
    assign in_ready   = rdy[0];
    assign out_valid  = vld[DEPTH];
    assign out_data   = dat[DEPTH];
    assign out_ctrl   = ctl[DEPTH];
    assign rdy[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_skid_stage #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (vld[g]),
            .in_data   (dat[g]),
            .in_ctrl   (ctl[g]),
            .in_ready  (rdy[g]),
            .out_valid (vld[g+1]),
            .out_data  (dat[g+1]),
            .out_ctrl  (ctl[g+1]),
            .out_ready (rdy[g+1])
        );
    end

    logic             acc_in;
    logic             acc_out;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign acc_in    = in_valid & rdy[0];
    assign acc_out   = vld[DEPTH] & out_ready;
    assign occupancy = occ_q;

    always_comb begin
        occ_d = occ_q + OCC_W'(acc_in) - OCC_W'(acc_out);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed and randomised checks of elastic_pipe_reg at DEPTH 1..4.
module tb_elastic_pipe_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  [ND];
    logic          fl   [ND];
    logic          iv   [ND];
    logic          ir   [ND];
    logic          ov   [ND];
    logic          ordy [ND];
    logic [DW-1:0] id   [ND];
    logic [DW-1:0] od   [ND];
    logic [CW-1:0] ic   [ND];
    logic [CW-1:0] oc   [ND];
    logic [31:0]   occ  [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int D  = g + 1;
        localparam int OW = $clog2(2 * D + 1);
        logic [OW-1:0] occ_w;
        elastic_pipe_reg #(
            .DATA_W (DW),
            .CTRL_W (CW),
            .DEPTH  (D)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .flush     (fl[g]),
            .in_valid  (iv[g]),
            .in_data   (id[g]),
            .in_ctrl   (ic[g]),
            .in_ready  (ir[g]),
            .out_valid (ov[g]),
            .out_data  (od[g]),
            .out_ctrl  (oc[g]),
            .out_ready (ordy[g]),
            .occupancy (occ_w)
        );
        assign occ[g] = 32'(occ_w);
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nacc, nout, seen, cnt;
        logic fin, fout;
        logic fin_a [ND];
        logic fout_a[ND];
        logic [31:0] fb [ND][64];
        int head[ND], tail[ND], seq[ND], maxocc[ND];

        for (int i = 0; i < ND; i++) begin
            rst[i] = 1'b1; fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0;
            id[i] = '0; ic[i] = '0;
        end
        step();
        step();
        for (int i = 0; i < ND; i++) begin
            check("rst_ov", ov[i], 0);
            check("rst_od", od[i], 0);
            check("rst_oc", oc[i], 0);
            check("rst_ir", ir[i], 1);
            check("rst_occ", occ[i], 0);
            rst[i] = 1'b0;
        end

        // Streaming, DEPTH=2, no backpressure
        ordy[1] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            int a, e;
            logic eo;
            iv[1] = (s <= 8);
            id[1] = s;
            ic[1] = 8'(s);
            step();
            a  = (s < 8) ? s : 8;
            e  = (s - 2 < 0) ? 0 : ((s - 2 > 8) ? 8 : s - 2);
            eo = (s >= 2 && s <= 9);
            check("t1_ov", ov[1], eo);
            if (eo) check("t1_od", od[1], s - 1);
            check("t1_occ", occ[1], a - e);
            check("t1_ir", ir[1], 1);
        end
        iv[1] = 1'b0;

        // Capacity under backpressure, then ordered drain
        ordy[1] = 1'b0;
        iv[1]   = 1'b1;
        nacc    = 0;
        for (int s = 1; s <= 6; s++) begin
            id[1] = 32'hA0 + nacc;
            fin   = ir[1];
            step();
            if (fin) nacc++;
            check("t2_ir", ir[1], s < 4);
            check("t2_occ", occ[1], (s < 4) ? s : 4);
        end
        check("t2_nacc", nacc, 4);
        ordy[1] = 1'b1;
        nout    = 0;
        for (int s = 0; s < 20 && nout < 6; s++) begin
            iv[1] = (nacc < 6);
            id[1] = 32'hA0 + nacc;
            fin   = iv[1] & ir[1];
            fout  = ov[1] & ordy[1];
            if (fout) begin
                check("t2_order", od[1], 32'hA0 + nout);
                nout++;
            end
            step();
            if (fin) nacc++;
        end
        check("t2_nout", nout, 6);
        iv[1] = 1'b0;

        // Flush with a beat presented in the same cycle
        ordy[1] = 1'b0;
        iv[1]   = 1'b1;
        ic[1]   = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            id[1] = 32'h30 + k;
            step();
        end
        check("t3_occ3", occ[1], 3);
        fl[1] = 1'b1;
        id[1] = 32'hDEAD;
        step();
        fl[1] = 1'b0;
        iv[1] = 1'b0;
        check("t3_ov", ov[1], 0);
        check("t3_oc", oc[1], 0);
        check("t3_od", od[1], 0);
        check("t3_occ", occ[1], 0);
        check("t3_ir", ir[1], 1);
        ordy[1] = 1'b1;
        seen    = 0;
        for (int s = 0; s < 6; s++) begin
            step();
            if (ov[1]) seen++;
        end
        check("t3_nodead", seen, 0);

        // Reset together with flush mid-stream
        ordy[1] = 1'b0;
        iv[1]   = 1'b1;
        ic[1]   = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            id[1] = 32'h40 + k;
            step();
        end
        check("t5_occ3", occ[1], 3);
        rst[1] = 1'b1;
        fl[1]  = 1'b1;
        id[1]  = 32'hBEEF;
        step();
        check("t5_ov", ov[1], 0);
        check("t5_od", od[1], 0);
        check("t5_oc", oc[1], 0);
        check("t5_occ", occ[1], 0);
        check("t5_ir", ir[1], 1);
        rst[1]  = 1'b0;
        fl[1]   = 1'b0;
        id[1]   = 32'h55;
        ic[1]   = 8'h3C;
        ordy[1] = 1'b1;
        step();
        iv[1] = 1'b0;
        check("t5_lat", ov[1], 0);
        step();
        check("t5_ov1", ov[1], 1);
        check("t5_od1", od[1], 32'h55);
        check("t5_oc1", oc[1], 8'h3C);
        step();
        check("t5_empty", occ[1], 0);

        // DEPTH=1 with out_ready toggling every cycle
        iv[0] = 1'b1;
        nacc  = 0;
        nout  = 0;
        for (int s = 1; s <= 10; s++) begin
            ordy[0] = (s % 2 == 0);
            id[0]   = 32'h10 + nacc;
            fin     = ir[0];
            fout    = ov[0] & ordy[0];
            if (fout) begin
                check("t6_order", od[0], 32'h10 + nout);
                nout++;
            end
            step();
            if (fin) nacc++;
            check("t6_occ", occ[0], (s < 3) ? 1 : ((s % 2 == 1) ? 2 : 1));
            check("t6_ov", ov[0], 1);
        end
        check("t6_nout", nout, 5);
        iv[0] = 1'b0;

        // Random traffic on all depths against a FIFO scoreboard
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0; fl[d] = 1'b0;
            head[d] = 0; tail[d] = 0; seq[d] = 0; maxocc[d] = 0;
        end
        step();
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int d = 0; d < ND; d++) begin
                iv[d]   = 1'($urandom_range(0, 1));
                ordy[d] = 1'($urandom_range(0, 1));
                id[d]   = {8'(d), 24'(seq[d])};
                ic[d]   = 8'(seq[d]);
                cnt     = tail[d] - head[d];
                if (d == 0) begin
                    check("rnd_d1_ir", ir[0], cnt < 2);
                    check("rnd_d1_ov", ov[0], cnt > 0);
                end
                fin_a[d]  = iv[d] & ir[d];
                fout_a[d] = ov[d] & ordy[d];
                if (fout_a[d]) begin
                    check("rnd_data", od[d], fb[d][head[d] % 64]);
                    head[d]++;
                end
                if (fin_a[d]) begin
                    fb[d][tail[d] % 64] = id[d];
                    tail[d]++;
                    seq[d]++;
                end
            end
            step();
            for (int d = 0; d < ND; d++) begin
                check("rnd_occ", occ[d], tail[d] - head[d]);
                if (tail[d] - head[d] > maxocc[d]) maxocc[d] = tail[d] - head[d];
            end
        end
        for (int d = 0; d < ND; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        for (int s = 0; s < 12; s++) begin
            for (int d = 0; d < ND; d++) begin
                if (ov[d]) begin
                    check("rnd_drain_data", od[d], fb[d][head[d] % 64]);
                    head[d]++;
                end
            end
            step();
        end
        for (int d = 0; d < ND; d++) begin
            check("rnd_max", maxocc[d] <= 2 * (d + 1), 1);
            check("rnd_left", tail[d] - head[d], 0);
            check("rnd_occ_end", occ[d], 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
